fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  // instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, one-outstanding imem fetch FSM, hold buffer, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pcp4_q, if_pcp4_d;
  logic        if_valid_q, if_valid_d;

  logic        req;
  logic        resp_live;
  logic        hold_use;
  logic [31:0] redirect_pc;

  // While WAITing, PCF still equals the address in flight, so it doubles as the fetch PC.
  assign redirect_pc    = PCTargetE & ~32'h3;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pcf_q;
  assign InstrD         = if_instr_q;
  assign PCD            = if_pc_q;
  assign PCPlus4D       = if_pcp4_q;
  assign ValidD         = if_valid_q;

  // Next-state for fetch FSM, PC, hold buffer and IF/ID register
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    hold_vld_d   = hold_vld_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pcp4_d    = if_pcp4_q;
    if_valid_d   = if_valid_q;
    req          = 1'b0;
    resp_live    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a redirect wins over issuing; stray rvalid here is ignored
        if (PCSrcE) begin
          pcf_d = redirect_pc;
        end else if (!StallF && !hold_vld_q && !rst) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pcf_d   = redirect_pc;
          state_d = imem.imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem.imem_rvalid) begin
          pcf_d     = pcf_q + 32'd4;
          state_d   = S_IDLE;
          resp_live = 1'b1;
        end
      end
      S_DROP: begin
        // the in-flight response belongs to the abandoned path
        if (PCSrcE) pcf_d = redirect_pc;
        if (imem.imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a parked instruction is wrong-path once a redirect is seen
    hold_use = hold_vld_q && !PCSrcE;

    if (FlushD) begin
      if_instr_d = NOP_INSTR;
      if_pc_d    = 32'd0;
      if_pcp4_d  = 32'd0;
      if_valid_d = 1'b0;
    end else if (StallD) begin
      if_valid_d = if_valid_q;
    end else if (hold_use) begin
      if_instr_d = hold_instr_q;
      if_pc_d    = hold_pc_q;
      if_pcp4_d  = hold_pc_q + 32'd4;
      if_valid_d = 1'b1;
      hold_vld_d = 1'b0;
    end else if (resp_live) begin
      if_instr_d = imem.imem_rdata;
      if_pc_d    = pcf_q;
      if_pcp4_d  = pcf_q + 32'd4;
      if_valid_d = 1'b1;
    end else begin
      if_instr_d = NOP_INSTR;
      if_pc_d    = 32'd0;
      if_pcp4_d  = 32'd0;
      if_valid_d = 1'b0;
    end

    // park a response that IF/ID cannot take this cycle
    if (resp_live && (FlushD || StallD)) begin
      hold_vld_d   = 1'b1;
      hold_instr_d = imem.imem_rdata;
      hold_pc_d    = pcf_q;
    end

    if (PCSrcE) hold_vld_d = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pcf_q        <= RESET_PC & ~32'h3;
      hold_vld_q   <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= 32'd0;
      if_pcp4_q    <= 32'd0;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      hold_vld_q   <= hold_vld_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pcp4_q    <= if_pcp4_d;
      if_valid_q   <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h00000000), .NOP_INSTR(32'h00000013)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend = 32'd0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'd0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pcp4, input logic valid);
    chk({tag, ".PCD"}, PCD, pc);
    chk({tag, ".InstrD"}, InstrD, instr);
    chk({tag, ".PCPlus4D"}, PCPlus4D, pcp4);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, valid});
  endtask

  // One clock cycle: record this cycle's request, cross the edge, then drive the memory model.
  task automatic cycle();
    #1;
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(pend);
      end
    end
    if (last_req) begin
      pend = last_addr;
      if (lat == 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(last_addr);
      end else begin
        cnt = lat - 1;
      end
    end
  endtask

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;

    // reset
    cycle();
    cycle();
    chk("rst.req", {31'd0, last_req}, 32'd0);
    chk_ifid("rst", 32'h0, 32'h13, 32'h0, 1'b0);
    rst = 1'b0;

    // 1-cycle memory, no stalls
    cycle();
    chk("c0.req", {31'd0, last_req}, 32'd1);
    chk("c0.addr", last_addr, 32'h0);
    cycle();
    chk("c1.req", {31'd0, last_req}, 32'd0);
    chk_ifid("c1", 32'h0, 32'hC0DE0000, 32'h4, 1'b1);
    cycle();
    chk("c2.req", {31'd0, last_req}, 32'd1);
    chk("c2.addr", last_addr, 32'h4);
    chk("c2.ValidD", {31'd0, ValidD}, 32'd0);
    cycle();
    chk_ifid("c3", 32'h4, 32'hC0DE0004, 32'h8, 1'b1);

    // StallD across the response for 0x8
    StallD = 1'b1;
    cycle();
    chk("c4.addr", last_addr, 32'h8);
    chk_ifid("c4", 32'h4, 32'hC0DE0004, 32'h8, 1'b1);
    cycle();
    chk_ifid("c5", 32'h4, 32'hC0DE0004, 32'h8, 1'b1);
    cycle();
    chk("c6.req", {31'd0, last_req}, 32'd0);
    cycle();
    chk("c7.req", {31'd0, last_req}, 32'd0);
    chk_ifid("c7", 32'h4, 32'hC0DE0004, 32'h8, 1'b1);
    StallD = 1'b0;
    cycle();
    chk("c8.req", {31'd0, last_req}, 32'd0);
    chk_ifid("c8", 32'h8, 32'hC0DE0008, 32'hC, 1'b1);
    cycle();
    chk("c9.req", {31'd0, last_req}, 32'd1);
    chk("c9.addr", last_addr, 32'hC);
    cycle();
    chk_ifid("c10", 32'hC, 32'hC0DE000C, 32'h10, 1'b1);

    // redirect during WAIT with 3-cycle memory
    lat = 3;
    cycle();
    chk("c11.addr", last_addr, 32'h10);
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    cycle();
    chk("c12.req", {31'd0, last_req}, 32'd0);
    PCSrcE = 1'b0;
    cycle();
    chk("c13.req", {31'd0, last_req}, 32'd0);
    cycle();
    chk("c14.req", {31'd0, last_req}, 32'd0);
    chk("c14.ValidD", {31'd0, ValidD}, 32'd0);
    cycle();
    chk("c15.req", {31'd0, last_req}, 32'd1);
    chk("c15.addr", last_addr, 32'h100);
    cycle();
    cycle();
    cycle();
    chk_ifid("c18", 32'h100, 32'hC0DE0100, 32'h104, 1'b1);

    // FlushD with a live response: bubble now, parked instruction next cycle
    lat = 1;
    cycle();
    chk("c19.addr", last_addr, 32'h104);
    FlushD = 1'b1;
    cycle();
    chk_ifid("c20", 32'h0, 32'h13, 32'h0, 1'b0);
    FlushD = 1'b0;
    cycle();
    chk("c21.req", {31'd0, last_req}, 32'd0);
    chk_ifid("c21", 32'h104, 32'hC0DE0104, 32'h108, 1'b1);

    // redirect in IDLE to an unaligned top-of-memory target
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFFFFFE;
    cycle();
    chk("c22.req", {31'd0, last_req}, 32'd0);
    PCSrcE = 1'b0;
    cycle();
    chk("c23.req", {31'd0, last_req}, 32'd1);
    chk("c23.addr", last_addr, 32'hFFFFFFFC);
    cycle();
    chk_ifid("c24", 32'hFFFFFFFC, 32'hC0DEFFFC, 32'h0, 1'b1);

    // reset while WAITing; stale response must be ignored
    lat = 3;
    cycle();
    chk("c25.req", {31'd0, last_req}, 32'd1);
    chk("c25.addr", last_addr, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    StallF = 1'b1;
    cycle();
    chk("c27.req", {31'd0, last_req}, 32'd0);
    cycle();
    chk("c28.req", {31'd0, last_req}, 32'd0);
    chk_ifid("c28", 32'h0, 32'h13, 32'h0, 1'b0);
    StallF = 1'b0;
    lat = 1;
    cycle();
    chk("c29.req", {31'd0, last_req}, 32'd1);
    chk("c29.addr", last_addr, 32'h0);
    cycle();
    chk_ifid("c30", 32'h0, 32'hC0DE0000, 32'h4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
